// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

  typedef enum logic [2:0] {
    StHdrLo,
    StHdrHi,
    StData,
    StCheck,
    StDone,
    StError
  } state_e;

  localparam int unsigned HdrBytes  = 2;
  localparam int unsigned WordBytes = 4;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream into little-endian words; word_valid_o pulses with the last byte of a word.
module word_assembler
  import loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_i,
  output logic                   word_valid_o,
  output logic [WordBytes*8-1:0] word_o
);

  localparam int unsigned LaneW = $clog2(WordBytes);
  localparam int unsigned PackW = (WordBytes - 1) * 8;

  logic [LaneW-1:0] lane_q, lane_d;
  logic [PackW-1:0] pack_q, pack_d;
  logic             last_lane;

  assign last_lane    = (lane_q == LaneW'(WordBytes - 1));
  assign word_valid_o = byte_valid_i && last_lane;
  // Earlier bytes sit in the low lanes, the completing byte lands on top.
  assign word_o       = {byte_i, pack_q};

  always_comb begin
    lane_d = lane_q;
    pack_d = pack_q;
    if (clear_i) begin
      lane_d = '0;
    end else if (byte_valid_i) begin
      lane_d = last_lane ? '0 : lane_q + 1'b1;
      pack_d = {byte_i, pack_q[PackW-1:8]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      pack_q <= '0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: writes a counted, XOR-checksummed byte image into instruction memory
// and keeps the CPU in reset until the image is accepted.
module instr_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  localparam int unsigned MaxWords = 2 ** ADDR_WIDTH;
  localparam int unsigned IdxW     = ADDR_WIDTH + 1;
  localparam int unsigned CntW     = 17;

  state_e            state_q, state_d;
  logic [7:0]        count_lo_q, count_lo_d;
  logic [15:0]       count_q, count_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic              rdy_q;
  logic              mem_we_q;
  logic [31:0]       mem_addr_q, mem_wdata_q;

  logic              accept;
  logic              loading;
  logic [15:0]       hdr_count;
  logic              asm_clear, asm_valid, word_valid;
  logic [31:0]       word;

  word_assembler u_word_assembler (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_valid),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  assign loading   = (state_q == StHdrLo) || (state_q == StHdrHi) ||
                     (state_q == StData)  || (state_q == StCheck);
  // rdy_q keeps in_ready low while reset is asserted even though state is already StHdrLo.
  assign in_ready  = rdy_q && loading;
  assign accept    = in_valid && in_ready;
  assign hdr_count = {in_data, count_lo_q};

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = (state_q != StDone);
  assign done      = (state_q == StDone);
  assign err       = (state_q == StError);

  always_comb begin
    state_d    = state_q;
    count_lo_d = count_lo_q;
    count_d    = count_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    asm_clear  = 1'b0;
    asm_valid  = 1'b0;
    unique case (state_q)
      StHdrLo: begin
        if (accept) begin
          count_lo_d = in_data;
          state_d    = StHdrHi;
        end
      end
      StHdrHi: begin
        if (accept) begin
          count_d   = hdr_count;
          idx_d     = '0;
          csum_d    = '0;
          asm_clear = 1'b1;
          if (CntW'(hdr_count) > CntW'(MaxWords)) begin
            state_d = StError;
          end else if (hdr_count == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          asm_valid = 1'b1;
          csum_d    = csum_q ^ in_data;
          if (word_valid) begin
            idx_d = idx_q + 1'b1;
            if (CntW'(idx_d) == CntW'(count_q)) begin
              state_d = StCheck;
            end
          end
        end
      end
      StCheck: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? StDone : StError;
        end
      end
      StDone, StError: ;
      default: state_d = StError;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHdrLo;
      count_lo_q  <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      rdy_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      count_lo_q <= count_lo_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      rdy_q      <= 1'b1;
      mem_we_q   <= word_valid;
      if (word_valid) begin
        mem_addr_q  <= 32'({idx_q, 2'b00});
        mem_wdata_q <= word;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: image loads, checksum/oversize rejection, stalls, mid-image reset.
module tb_instr_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];

  instr_loader #(.ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wa.delete();
    wd.delete();
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_stalled(input logic [7:0] b);
    int gap;
    gap = $urandom_range(0, 3);
    for (int k = 0; k < gap; k++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    send(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset values
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // Two words, checksum 0x13^0x05^0x10^0x93^0x05^0x20 = 0xB0
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h05); send(8'h10); send(8'h00);
    send(8'h93); send(8'h05); send(8'h20); send(8'h00);
    send(8'hB0);
    chk("a_done", 32'(done), 32'd1);
    chk("a_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("a_err", 32'(err), 32'd0);
    chk("a_in_ready", 32'(in_ready), 32'd0);
    idle(3);
    chk("a_nwrites", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk("a_addr0", wa[0], 32'h0);
      chk("a_data0", wd[0], 32'h0010_0513);
      chk("a_addr1", wa[1], 32'h4);
      chk("a_data1", wd[1], 32'h0020_0593);
    end
    chk("a_addr_held", mem_addr, 32'h4);
    chk("a_data_held", mem_wdata, 32'h0020_0593);

    // Same image, bad checksum
    do_reset();
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h05); send(8'h10); send(8'h00);
    send(8'h93); send(8'h05); send(8'h20); send(8'h00);
    send(8'h01);
    chk("b_err", 32'(err), 32'd1);
    chk("b_done", 32'(done), 32'd0);
    chk("b_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("b_in_ready", 32'(in_ready), 32'd0);
    idle(2);
    chk("b_nwrites", 32'(wa.size()), 32'd2);

    // Oversize count 0x0101
    do_reset();
    send(8'h01); send(8'h01);
    chk("c_err", 32'(err), 32'd1);
    chk("c_in_ready", 32'(in_ready), 32'd0);
    send(8'h55); send(8'h66);
    idle(2);
    chk("c_nwrites", 32'(wa.size()), 32'd0);
    chk("c_done", 32'(done), 32'd0);

    // Empty image, good then bad checksum
    do_reset();
    send(8'h00); send(8'h00); send(8'h00);
    chk("d_done", 32'(done), 32'd1);
    chk("d_cpu_rst", 32'(cpu_rst), 32'd0);
    idle(2);
    chk("d_nwrites", 32'(wa.size()), 32'd0);
    do_reset();
    send(8'h00); send(8'h00); send(8'h5A);
    chk("d2_err", 32'(err), 32'd1);
    chk("d2_done", 32'(done), 32'd0);

    // One word with random stalls; AA^BB^CC^DD = 0x00
    do_reset();
    send_stalled(8'h01); send_stalled(8'h00);
    send_stalled(8'hAA); send_stalled(8'hBB); send_stalled(8'hCC); send_stalled(8'hDD);
    send_stalled(8'h00);
    chk("e_done", 32'(done), 32'd1);
    idle(2);
    chk("e_nwrites", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("e_addr", wa[0], 32'h0);
      chk("e_data", wd[0], 32'hDDCC_BBAA);
    end

    // Reset mid-image, then reload; EF^BE^AD^DE = 0x22
    do_reset();
    send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    chk("f_pre_wdata", mem_wdata, 32'h4433_2211);
    rst_n = 1'b0;
    #1;
    chk("f_rst_wdata", mem_wdata, 32'h0);
    chk("f_rst_addr", mem_addr, 32'h0);
    chk("f_rst_we", 32'(mem_we), 32'd0);
    chk("f_rst_ready", 32'(in_ready), 32'd0);
    chk("f_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    do_reset();
    send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    send(8'h22);
    chk("f_done", 32'(done), 32'd1);
    idle(2);
    chk("f_nwrites", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("f_addr", wa[0], 32'h0);
      chk("f_data", wd[0], 32'hDEAD_BEEF);
    end

    // Full-size image: 256 words, word i = four copies of byte i, checksum 0
    do_reset();
    send(8'h00); send(8'h01);
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 4; j++) send(8'(i));
    end
    send(8'h00);
    chk("g_done", 32'(done), 32'd1);
    idle(2);
    chk("g_nwrites", 32'(wa.size()), 32'd256);
    if (wa.size() == 256) begin
      chk("g_addr1", wa[1], 32'h4);
      chk("g_data1", wd[1], 32'h0101_0101);
      chk("g_addr_last", wa[255], 32'h3FC);
      chk("g_data_last", wd[255], 32'hFFFF_FFFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
